// File: rtl/hex_seg_scan.sv
// -----------------------------------------------------------------------------
// hex_seg_scan
//
// Time-multiplexed N-digit hexadecimal 7-segment display controller.
//
// Software writes digit data (hex nibble, decimal point, blink enable, digit
// enable) with a one-cycle load strobe. The data goes into a shadow register
// and is committed to the active register only at a frame boundary, so a
// frame is never drawn from a mix of old and new data. A load that lands on
// the frame-boundary cycle itself is committed straight away.
//
// The active data drives two registered views:
//   * an/seg  : one digit at a time, advancing every 2^SCAN_DIV clocks
//   * seg_txt : all digits at once, for serial shift-out boards
//
// Parameters
//   DIGITS    number of digits (1..16); digit 0 = hexs[3:0], rightmost
//   SCAN_DIV  scan prescaler width; digit advances every 2^SCAN_DIV clk
//   FLASH_DIV blink counter width; blink phase = counter MSB
//   AN_LOW    1: anode selects active-low, 0: active-high
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   one-cycle strobe: capture hexs/points/les/dig_en
//   hexs     in   4*DIGITS  hex nibble per digit
//   points   in   DIGITS    1 = decimal point lit
//   les      in   DIGITS    1 = digit blinks (blank while blink phase = 1)
//   dig_en   in   DIGITS    1 = digit shown, 0 = always blank
//   an       out  DIGITS    one-hot digit select, registered
//   seg      out  8         {a,b,c,d,e,f,g,p} active-low, registered
//   seg_txt  out  8*DIGITS  byte i = active-low pattern of digit i, registered
//   frame    out  1         one-cycle pulse on the commit/wrap cycle
// -----------------------------------------------------------------------------
module hex_seg_scan #(
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 17,
   parameter int FLASH_DIV = 25,
   parameter bit AN_LOW    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hexs,
   input  logic [DIGITS-1:0]     points,
   input  logic [DIGITS-1:0]     les,
   input  logic [DIGITS-1:0]     dig_en,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg,
   output logic [8*DIGITS-1:0]   seg_txt,
   output logic                  frame
);

   // --------------------------------------------------------------------------
   // Local constants and types
   // --------------------------------------------------------------------------
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
   localparam logic [SCAN_DIV-1:0]  SCAN_ONE  = SCAN_DIV'(1);
   localparam logic [FLASH_DIV-1:0] FLASH_ONE = FLASH_DIV'(1);

   // Everything software supplies for one display image.
   typedef struct packed {
      logic [4*DIGITS-1:0] hexs;
      logic [DIGITS-1:0]   points;
      logic [DIGITS-1:0]   les;
      logic [DIGITS-1:0]   dig_en;
   } disp_t;

   // Hex nibble to full active-low byte {a..g, p} with the point off.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
      logic [7:0] b;
      case (h)
         4'h0: b = 8'h03;
         4'h1: b = 8'h9F;
         4'h2: b = 8'h25;
         4'h3: b = 8'h0D;
         4'h4: b = 8'h99;
         4'h5: b = 8'h49;
         4'h6: b = 8'h41;
         4'h7: b = 8'h1F;
         4'h8: b = 8'h01;
         4'h9: b = 8'h09;
         4'hA: b = 8'h11;
         4'hB: b = 8'hC1;
         4'hC: b = 8'h63;
         4'hD: b = 8'h85;
         4'hE: b = 8'h61;
         default: b = 8'h71;
      endcase
      return b;
   endfunction

   // --------------------------------------------------------------------------
   // Signals
   // --------------------------------------------------------------------------
   disp_t                in_data;
   disp_t                shadow_q, shadow_d;
   disp_t                active_q, active_d;
   logic                 pending_q, pending_d;

   logic [SCAN_DIV-1:0]  scan_cnt_q, scan_cnt_d;
   logic [FLASH_DIV-1:0] flash_cnt_q, flash_cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic                 tick;
   logic                 frame_end;
   logic                 ph;

   logic [7:0]           pat [DIGITS];
   logic [DIGITS-1:0]    an_q, an_d;
   logic [7:0]           seg_q, seg_d;
   logic [8*DIGITS-1:0]  seg_txt_q, seg_txt_d;
   logic                 frame_q;

   assign in_data = '{hexs: hexs, points: points, les: les, dig_en: dig_en};

   // --------------------------------------------------------------------------
   // Scan, blink and capture/commit control
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      scan_cnt_d  = scan_cnt_q + SCAN_ONE;
      flash_cnt_d = flash_cnt_q + FLASH_ONE;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      pending_d   = pending_q;

      tick      = (scan_cnt_q == '1);
      frame_end = tick && (idx_q == LAST_IDX);

      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
      end

      // Last load wins: a later strobe simply overwrites the shadow.
      if (load) begin
         shadow_d  = in_data;
         pending_d = 1'b1;
      end

      // A load on the boundary cycle bypasses the shadow so it is not delayed
      // by a whole frame; otherwise commit whatever is pending.
      if (frame_end) begin
         if (load) begin
            active_d  = in_data;
            pending_d = 1'b0;
         end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Per-digit patterns and output next-state
   // --------------------------------------------------------------------------
   always_comb begin
      ph        = flash_cnt_q[FLASH_DIV-1];
      an_d      = {DIGITS{AN_LOW}};
      seg_d     = 8'hFF;
      seg_txt_d = '1;

      for (int i = 0; i < DIGITS; i++) begin
         if (!active_q.dig_en[i] || (active_q.les[i] && ph)) begin
            pat[i] = 8'hFF;
         end else begin
            // Table bytes carry p=1; clear it when the point is lit.
            pat[i] = hex_to_seg(active_q.hexs[4*i +: 4]) & {7'h7F, ~active_q.points[i]};
         end
         seg_txt_d[8*i +: 8] = pat[i];
      end

      // an and seg come from the same idx_q and the same patterns, so they
      // always update together.
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            an_d[i] = ~AN_LOW;
            seg_d   = pat[i];
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         flash_cnt_q <= '0;
         idx_q       <= '0;
         pending_q   <= 1'b0;
         // NOTE: shadow/active are flop registers, not a RAM, so they are
         // reset; active.dig_en = 0 is what keeps the display blank until the
         // first commit.
         shadow_q    <= '0;
         active_q    <= '0;
         an_q        <= {DIGITS{AN_LOW}};
         seg_q       <= 8'hFF;
         seg_txt_q   <= '1;
         frame_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         scan_cnt_q  <= scan_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         seg_txt_q   <= seg_txt_d;
         frame_q     <= frame_end;
      end
   end

   assign an      = an_q;
   assign seg     = seg_q;
   assign seg_txt = seg_txt_q;
   assign frame   = frame_q;

endmodule
